// File: rtl/cpu_run_controller_if.sv
// Handshake and status bundle between the run controller and the bench/processor side.
// Signal directions are named from the controller's point of view.
interface cpu_run_controller_if #(
    parameter int NUM_CORES = 1,
    parameter int CNT_W     = 16
);
    logic                 i_run_en;
    logic                 i_step;
    logic                 i_restart;
    logic [NUM_CORES-1:0] i_zero;
    logic                 o_cpu_reset;
    logic                 o_cpu_clk_en;
    logic [CNT_W-1:0]     o_cycle_count;
    logic [NUM_CORES-1:0] o_halted;
    logic                 o_done;
    logic                 o_timeout;

    modport master (
        output i_run_en, i_step, i_restart, i_zero,
        input  o_cpu_reset, o_cpu_clk_en, o_cycle_count, o_halted, o_done, o_timeout
    );

    modport slave (
        input  i_run_en, i_step, i_restart, i_zero,
        output o_cpu_reset, o_cpu_clk_en, o_cycle_count, o_halted, o_done, o_timeout
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run controller for a group of processors: reset hold, free-run/pause/step,
// per-core halt detection from stable zero flags, and cycle-budget timeout.
module cpu_run_controller #(
    parameter int NUM_CORES    = 1,
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 7,
    parameter int HALT_STABLE  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_run_controller_if.slave bus
);

    typedef enum logic [1:0] {HOLD, RUN, PAUSE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] BUDGET     = CNT_W'(MAX_CYCLES);
    localparam logic [7:0]       HOLD_LAST  = 8'(RESET_CYCLES - 1);
    localparam logic [7:0]       STABLE_TGT = 8'(HALT_STABLE);

    state_t               r_state;
    logic [7:0]           r_holdCnt;
    logic [7:0]           r_stableCnt [NUM_CORES];
    logic [CNT_W-1:0]     r_cycleCnt;
    logic [NUM_CORES-1:0] r_halted;
    logic                 r_cpuReset;
    logic                 r_done;
    logic                 r_timeout;

    logic                 w_clkEn;
    logic [CNT_W-1:0]     w_cycleNext;
    logic [NUM_CORES-1:0] w_haltedNext;
    logic                 w_allHalted;
    logic                 w_budgetHit;

    // Restart suppresses any enable in its cycle so the processors never advance while being re-reset.
    always_comb begin
        w_clkEn = 1'b0;
        if (!bus.i_restart) begin
            if (r_state == RUN) begin
                w_clkEn = 1'b1;
            end else if (r_state == PAUSE) begin
                w_clkEn = bus.i_step;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_haltedNext[i] = r_halted[i] |
                              (bus.i_zero[i] && ((r_stableCnt[i] + 8'd1) == STABLE_TGT));
        end
    end

    assign w_cycleNext = (r_cycleCnt == CNT_MAX) ? r_cycleCnt : r_cycleCnt + CNT_W'(1);
    assign w_allHalted = &w_haltedNext;
    assign w_budgetHit = (w_cycleNext >= BUDGET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HOLD;
            r_holdCnt  <= '0;
            r_cycleCnt <= '0;
            r_halted   <= '0;
            r_cpuReset <= 1'b1;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_stableCnt[i] <= '0;
            end
        end else if (bus.i_restart) begin
            r_state    <= HOLD;
            r_holdCnt  <= '0;
            r_cycleCnt <= '0;
            r_halted   <= '0;
            r_cpuReset <= 1'b1;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_stableCnt[i] <= '0;
            end
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_holdCnt == HOLD_LAST) begin
                        r_state    <= bus.i_run_en ? RUN : PAUSE;
                        r_cpuReset <= 1'b0;
                    end else begin
                        r_holdCnt <= r_holdCnt + 8'd1;
                    end
                end
                RUN: begin
                    if (!bus.i_run_en) r_state <= PAUSE;
                end
                PAUSE: begin
                    if (bus.i_run_en) r_state <= RUN;
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: r_state <= HOLD;
            endcase

            // Halt takes precedence over timeout when both land on the same enabled cycle.
            if (w_clkEn) begin
                r_cycleCnt <= w_cycleNext;
                r_halted   <= w_haltedNext;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (bus.i_zero[i]) begin
                        if (r_stableCnt[i] != STABLE_TGT) r_stableCnt[i] <= r_stableCnt[i] + 8'd1;
                    end else begin
                        r_stableCnt[i] <= '0;
                    end
                end
                if (w_allHalted) begin
                    r_state   <= DONE;
                    r_done    <= 1'b1;
                    r_timeout <= 1'b0;
                end else if (w_budgetHit) begin
                    r_state   <= DONE;
                    r_done    <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.o_cpu_reset   = r_cpuReset;
    assign bus.o_cpu_clk_en  = w_clkEn;
    assign bus.o_cycle_count = r_cycleCnt;
    assign bus.o_halted      = r_halted;
    assign bus.o_done        = r_done;
    assign bus.o_timeout     = r_timeout;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a behavioural model tracks the default-parameter instance
// every cycle; two further instances cover multi-core halt and the halt-vs-budget tie.
module tb_cpu_run_controller;

    localparam int RESET_CYCLES = 2;
    localparam int MAX_CYCLES   = 7;
    localparam int HALT_STABLE  = 3;

    logic clk;
    logic rstA, rstB, rstC;

    cpu_run_controller_if #(.NUM_CORES(1), .CNT_W(16)) ifA ();
    cpu_run_controller_if #(.NUM_CORES(2), .CNT_W(16)) ifB ();
    cpu_run_controller_if #(.NUM_CORES(1), .CNT_W(16)) ifC ();

    cpu_run_controller dutA (.clk(clk), .rst_n(rstA), .bus(ifA.slave));
    cpu_run_controller #(.NUM_CORES(2), .MAX_CYCLES(20)) dutB (.clk(clk), .rst_n(rstB), .bus(ifB.slave));
    cpu_run_controller #(.MAX_CYCLES(3)) dutC (.clk(clk), .rst_n(rstC), .bus(ifC.slave));

    int total;
    int bad;
    int nReset;
    int nEn;
    bit zp [6];

    // Behavioural model of instance A: phase described by remaining hold cycles, finished flag
    // and the free-run decision taken from run_en on the previous edge.
    int mHoldLeft;
    int mCount;
    int mRun;
    bit mFinished;
    bit mTimeout;
    bit mFree;
    bit mHalted;
    bit expEn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit runEn, input bit step, input bit restart, input bit zero);
        @(posedge clk);
        #1;
        ifA.i_run_en  = runEn;
        ifA.i_step    = step;
        ifA.i_restart = restart;
        ifA.i_zero    = zero;
    endtask

    task automatic modelClear();
        mHoldLeft = RESET_CYCLES;
        mCount    = 0;
        mRun      = 0;
        mFinished = 1'b0;
        mTimeout  = 1'b0;
        mFree     = 1'b0;
        mHalted   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rstA) modelClear();
        expEn = (mHoldLeft == 0) && !mFinished && !ifA.i_restart && (mFree || ifA.i_step);
        checkOutput("A.cpu_reset",   32'(ifA.o_cpu_reset),   32'(mHoldLeft > 0));
        checkOutput("A.cpu_clk_en",  32'(ifA.o_cpu_clk_en),  32'(expEn));
        checkOutput("A.cycle_count", 32'(ifA.o_cycle_count), 32'(mCount));
        checkOutput("A.halted",      32'(ifA.o_halted),      32'(mHalted));
        checkOutput("A.done",        32'(ifA.o_done),        32'(mFinished));
        checkOutput("A.timeout",     32'(ifA.o_timeout),     32'(mTimeout));
        if (rstA) begin
            if (ifA.i_restart) begin
                modelClear();
            end else if (mHoldLeft > 0) begin
                mHoldLeft--;
                if (mHoldLeft == 0) mFree = ifA.i_run_en;
            end else if (!mFinished) begin
                if (expEn) begin
                    if (mCount < 65535) mCount++;
                    mRun = ifA.i_zero[0] ? mRun + 1 : 0;
                    if (mRun >= HALT_STABLE) mHalted = 1'b1;
                    if (mHalted) begin
                        mFinished = 1'b1;
                        mTimeout  = 1'b0;
                    end else if (mCount >= MAX_CYCLES) begin
                        mFinished = 1'b1;
                        mTimeout  = 1'b1;
                    end
                end
                mFree = ifA.i_run_en;
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        zp    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        ifA.i_run_en = 1'b1; ifA.i_step = 1'b0; ifA.i_restart = 1'b0; ifA.i_zero = 1'b0;
        ifB.i_run_en = 1'b0; ifB.i_step = 1'b0; ifB.i_restart = 1'b0; ifB.i_zero = 2'b00;
        ifC.i_run_en = 1'b0; ifC.i_step = 1'b0; ifC.i_restart = 1'b0; ifC.i_zero = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("A.rstCpuReset", 32'(ifA.o_cpu_reset), 32'd1);
        checkOutput("A.rstClkEn",    32'(ifA.o_cpu_clk_en), 32'd0);

        // Free run with zero low until the budget expires.
        @(posedge clk);
        #1;
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        nReset = 0;
        nEn    = 0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (ifA.o_cpu_reset) nReset++;
            if (ifA.o_cpu_clk_en) nEn++;
        end
        checkOutput("A.resetHighCycles", 32'(nReset), 32'd2);
        checkOutput("A.enabledCycles",   32'(nEn), 32'd7);
        checkOutput("A.budgetCount",     32'(ifA.o_cycle_count), 32'd7);
        checkOutput("A.budgetDone",      32'(ifA.o_done), 32'd1);
        checkOutput("A.budgetTimeout",   32'(ifA.o_timeout), 32'd1);

        // Restart together with step in DONE gives no enabled cycle.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("A.restartStepEn", 32'(ifA.o_cpu_clk_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("A.restartCpuReset", 32'(ifA.o_cpu_reset), 32'd1);
        checkOutput("A.restartCount",    32'(ifA.o_cycle_count), 32'd0);
        checkOutput("A.restartDone",     32'(ifA.o_done), 32'd0);

        // Paused with three spaced step pulses.
        nEn = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, (k == 3 || k == 6 || k == 9), 1'b0, 1'b0);
            @(negedge clk);
            if (ifA.o_cpu_clk_en) nEn++;
        end
        checkOutput("A.stepEnabled", 32'(nEn), 32'd3);
        checkOutput("A.stepCount",   32'(ifA.o_cycle_count), 32'd3);
        checkOutput("A.stepDone",    32'(ifA.o_done), 32'd0);

        // Zero pattern 1,1,0,1,1,1 after a restart; zero held high during HOLD must not count.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, zp[k]);
            @(negedge clk);
        end
        checkOutput("A.notYetHalted", 32'(ifA.o_halted), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("A.haltHalted",  32'(ifA.o_halted), 32'd1);
        checkOutput("A.haltDone",    32'(ifA.o_done), 32'd1);
        checkOutput("A.haltTimeout", 32'(ifA.o_timeout), 32'd0);
        checkOutput("A.haltCount",   32'(ifA.o_cycle_count), 32'd6);

        // Asynchronous reset during the fourth enabled cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        rstA = 1'b0;
        @(negedge clk);
        checkOutput("A.midRunCpuReset", 32'(ifA.o_cpu_reset), 32'd1);
        checkOutput("A.midRunCount",    32'(ifA.o_cycle_count), 32'd0);
        checkOutput("A.midRunClkEn",    32'(ifA.o_cpu_clk_en), 32'd0);
        @(posedge clk);
        #1;
        rstA = 1'b1;
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("A.rerunCount",   32'(ifA.o_cycle_count), 32'd7);
        checkOutput("A.rerunTimeout", 32'(ifA.o_timeout), 32'd1);

        // Two cores: core 0 stable from cycle 1, core 1 only on cycles 4-6.
        @(negedge clk);
        checkOutput("B.pausedCount", 32'(ifB.o_cycle_count), 32'd0);
        @(posedge clk);
        #1;
        ifB.i_run_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            ifB.i_zero[0] = 1'b1;
            ifB.i_zero[1] = (k >= 4 && k <= 6);
            @(negedge clk);
            if (k == 1) checkOutput("B.firstEnabled", 32'(ifB.o_cpu_clk_en), 32'd1);
            if (k == 4) checkOutput("B.core0Halted", 32'(ifB.o_halted), 32'd1);
            if (k == 6) checkOutput("B.notAllHalted", 32'(ifB.o_done), 32'd0);
        end
        checkOutput("B.bothHalted", 32'(ifB.o_halted), 32'd3);
        checkOutput("B.done",       32'(ifB.o_done), 32'd1);
        checkOutput("B.timeout",    32'(ifB.o_timeout), 32'd0);
        checkOutput("B.count",      32'(ifB.o_cycle_count), 32'd6);
        checkOutput("B.clkEnOff",   32'(ifB.o_cpu_clk_en), 32'd0);

        // Halt and budget reached on the same enabled cycle.
        @(posedge clk);
        #1;
        ifC.i_run_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            ifC.i_zero = 1'b1;
            @(negedge clk);
            if (k == 3) checkOutput("C.beforeTieCount", 32'(ifC.o_cycle_count), 32'd2);
        end
        checkOutput("C.done",    32'(ifC.o_done), 32'd1);
        checkOutput("C.timeout", 32'(ifC.o_timeout), 32'd0);
        checkOutput("C.count",   32'(ifC.o_cycle_count), 32'd3);
        checkOutput("C.halted",  32'(ifC.o_halted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameter NUM_CORES, default 1: number of processor instances controlled; each supplies one zero flag.
REQ-002 Parameter CNT_W, default 16: width of the enabled-cycle counter.
REQ-003 Parameter RESET_CYCLES, default 2: cycles cpu_reset stays high after reset release; legal range 1 to 255.
REQ-004 Parameter MAX_CYCLES, default 7: enabled-cycle budget before timeout; legal range 1 to 2^CNT_W-1.
REQ-005 Parameter HALT_STABLE, default 3: consecutive enabled cycles zero must hold high to mark a core halted; legal range 1 to 255.
REQ-006 clock  in  1  single system clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 run_en  in  1  level; 1 = free-run, 0 = pause.
REQ-009 step  in  1  one-cycle pulse; in PAUSE, enables the processors for that cycle.
REQ-010 restart  in  1  one-cycle pulse; re-enters HOLD from any state.
REQ-011 zero  in  NUM_CORES  per-core zero flag from each processor.
REQ-012 cpu_reset  out  1  active-high reset driven to all processors.
REQ-013 cpu_clk_en  out  1  processor clock enable; 1 = processors advance this cycle.
REQ-014 cycle_count  out  CNT_W  enabled cycles since leaving HOLD.
REQ-015 halted  out  NUM_CORES  sticky per-core halt flags.
REQ-016 done  out  1  sticky; run finished.
REQ-017 timeout  out  1  sticky; run finished by budget exhaustion, not by halt.

Function
REQ-018 State machine SHALL have states HOLD, RUN, PAUSE, DONE.
REQ-019 HOLD: cpu_reset=1, cpu_clk_en=0; hold counter increments each cycle; at count RESET_CYCLES-1 go to RUN if run_en=1, else PAUSE.
REQ-020 cpu_reset SHALL be a registered decode of state==HOLD, high for exactly RESET_CYCLES cycles after reset release.
REQ-021 RUN: cpu_clk_en=1; run_en=0 moves to PAUSE next cycle, with the current cycle still enabled.
REQ-022 PAUSE: cpu_clk_en=step (combinational); run_en=1 moves to RUN next cycle.
REQ-023 DONE: cpu_clk_en=0, cpu_reset=0; state held until restart or reset.
REQ-024 cycle_count SHALL increment by 1 on every cycle with cpu_clk_en=1 and saturate at 2^CNT_W-1.
REQ-025 Per core i, a stable counter SHALL increment on enabled cycles with zero[i]=1 and clear on enabled cycles with zero[i]=0; it is unchanged on non-enabled cycles.
REQ-026 halted[i] SHALL set on the enabled cycle whose update brings the stable counter to HALT_STABLE, and stay set until restart or reset.
REQ-027 Transition to DONE SHALL occur the cycle after all halted bits are 1 (done=1, timeout=0), or after cycle_count reaches MAX_CYCLES (done=1, timeout=1).
REQ-028 If the last halt bit and the budget are reached on the same enabled cycle, the halt condition SHALL win: timeout=0.
REQ-029 restart SHALL take priority over step, run_en and DONE entry; it clears cycle_count, stable counters, halted, done, timeout and the hold counter, and enters HOLD next cycle.
REQ-030 zero SHALL be ignored in HOLD and DONE.

Reset
REQ-031 reset=0 SHALL immediately force HOLD, cpu_reset=1, cpu_clk_en=0, cycle_count=0, halted=0, done=0, timeout=0, and clear all internal counters, regardless of state.
REQ-032 Release of reset SHALL start the RESET_CYCLES hold count on the first rising edge with reset=1.

Verification
REQ-033 Defaults, run_en=1, zero=0, reset released -> cpu_reset high 2 cycles, cpu_clk_en high 7 cycles, cycle_count=7, done=1, timeout=1, cpu_clk_en=0 thereafter.
REQ-034 NUM_CORES=2, MAX_CYCLES=20; zero[0]=1 from enabled cycle 1; zero[1]=1 on enabled cycles 4-6 -> halted=01 after cycle 3, halted=11 after cycle 6, done=1, timeout=0, cycle_count=6.
REQ-035 run_en=0, three step pulses spaced apart -> cpu_clk_en high exactly 3 cycles, cycle_count=3, state stays PAUSE.
REQ-036 zero high for 2 cycles, low 1 cycle, high 3 cycles -> halted=1 only after the final third high cycle, cycle_count=6.
REQ-037 MAX_CYCLES=3, zero=1 from enabled cycle 1 -> done=1, timeout=0, cycle_count=3.
REQ-038 reset low at enabled cycle 4 of RUN -> same cycle cpu_reset=1, cycle_count=0; in DONE, restart with step asserted together -> HOLD, counters cleared, no enabled cycle.
